// File: rtl/decimal_operand_entry.sv
// ---------------------------------------------------------------------------
// decimal_operand_entry
//
// Collects decimal digits keyed one at a time into a BCD entry register and,
// on commit, converts that register serially (one digit per clock, most
// significant first) into a saturating binary operand for the arithmetic
// units. The BCD register is also exported so the display can echo the entry.
//
// Optional feature:
//   DECIMAL_OPERAND_ENTRY_DEBOUNCE_EN  defined -> each synchronised button
//   passes a stability filter of DEBOUNCE_CYCLES clocks before edge detection.
//   Undefined (default) -> no filter; DEBOUNCE_CYCLES is unused.
//
// Ports:
//   clk            in   1          system clock, rising edge
//   reset          in   1          asynchronous, active-high reset
//   key_code       in   4          digit value sampled on the strobe event
//   key_strobe     in   1          raw button: digit key
//   key_enter      in   1          raw button: commit the entry
//   key_clear      in   1          raw button: discard the entry
//   operand        out  WIDTH      converted binary value, held until next commit
//   operand_valid  out  1          1-cycle pulse when operand updates
//   overflow       out  1          last committed value exceeded 2^WIDTH-1
//   digits         out  4*NDIGITS  BCD entry register, least significant in [3:0]
//   digit_count    out  3          digits currently held, 0..NDIGITS
//   busy           out  1          high while converting / presenting the result
// ---------------------------------------------------------------------------
module decimal_operand_entry #(
  parameter int WIDTH           = 7,
  parameter int NDIGITS         = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             key_code,
  input  logic                   key_strobe,
  input  logic                   key_enter,
  input  logic                   key_clear,
  output logic [WIDTH-1:0]       operand,
  output logic                   operand_valid,
  output logic                   overflow,
  output logic [4*NDIGITS-1:0]   digits,
  output logic [2:0]             digit_count,
  output logic                   busy
);

  localparam int ACC_W = WIDTH + 4;
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int DIG_W = 4 * NDIGITS;
  localparam logic [ACC_W-1:0] ACC_MAX = {4'b0000, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Button synchronisers, bit order {clear, enter, strobe}
  // -------------------------------------------------------------------------
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_level;

  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {key_clear, key_enter, key_strobe};
      r_sync2 <= r_sync1;
    end
  end

`ifdef DECIMAL_OPERAND_ENTRY_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  // The filtered level follows the synchronised level only after the latter
  // has differed from it for DEBOUNCE_CYCLES consecutive clocks; any return
  // to agreement restarts the count, so short glitches never get through.
  for (genvar g = 0; g < 3; g++) begin : g_debounce
    logic [DB_W-1:0] r_cnt;
    logic            r_filt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt  <= '0;
        r_filt <= 1'b0;
      end else if (r_sync2[g] != r_filt) begin
        if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_filt <= r_sync2[g];
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_level[g] = r_filt;
  end
`else
  assign w_level = r_sync2;
`endif

  // -------------------------------------------------------------------------
  // Rising-edge detection: one event per press
  // -------------------------------------------------------------------------
  logic [2:0] r_level_d;
  logic [2:0] w_event;
  logic       w_strobe_ev;
  logic       w_enter_ev;
  logic       w_clear_ev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_level_d <= '0;
    else       r_level_d <= w_level;
  end

  assign w_event     = w_level & ~r_level_d;
  assign w_strobe_ev = w_event[0];
  assign w_enter_ev  = w_event[1];
  assign w_clear_ev  = w_event[2];

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_next;
  logic [DIG_W-1:0]   r_digits;
  logic [2:0]         r_count;
  logic [ACC_W-1:0]   r_acc;
  logic [IDX_W-1:0]   r_idx;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_operand;
  logic               r_overflow;

  logic [3:0]         w_cur_digit;
  logic [ACC_W-1:0]   w_acc_calc;
  logic               w_acc_ovf;
  logic               w_digit_ok;
  logic [WIDTH-1:0]   w_result;
  logic               w_done;

  assign w_cur_digit = r_digits[{r_idx, 2'b00} +: 4];
  // acc is clamped to ACC_MAX, so acc*10 + 9 always fits in WIDTH+4 bits.
  assign w_acc_calc  = r_acc * ACC_W'(10) + {{(ACC_W-4){1'b0}}, w_cur_digit};
  assign w_acc_ovf   = (w_acc_calc > ACC_MAX);
  assign w_digit_ok  = (key_code <= 4'd9) && (r_count < 3'(NDIGITS));
  assign w_result    = r_ovf ? {WIDTH{1'b1}} : r_acc[WIDTH-1:0];
  // A clear landing in DONE cancels the commit, so the pulse is gated here.
  assign w_done      = (r_state == S_DONE) && !w_clear_ev;

  // NOTE: the combinational block assigns its output a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_enter_ev) w_state_next = S_CONVERT;
      S_CONVERT: if (r_idx == '0) w_state_next = S_DONE;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    if (w_clear_ev) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digits   <= '0;
      r_count    <= '0;
      r_acc      <= '0;
      r_idx      <= '0;
      r_ovf      <= 1'b0;
      r_operand  <= '0;
      r_overflow <= 1'b0;
    end else if (w_clear_ev) begin
      r_digits   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Strobe and enter together: the digit lands first, and CONVERT
          // reads r_digits a cycle later, so it sees the new digit.
          if (w_strobe_ev && w_digit_ok) begin
            r_digits <= {r_digits[DIG_W-5:0], key_code};
            r_count  <= r_count + 3'd1;
          end
          if (w_enter_ev) begin
            r_acc      <= '0;
            r_idx      <= IDX_W'(NDIGITS - 1);
            r_ovf      <= 1'b0;
            r_overflow <= 1'b0;
          end
        end
        S_CONVERT: begin
          r_acc <= w_acc_ovf ? ACC_MAX : w_acc_calc;
          if (w_acc_ovf) r_ovf <= 1'b1;
          r_idx <= r_idx - 1'b1;
        end
        S_DONE: begin
          r_operand  <= w_result;
          r_overflow <= r_ovf;
        end
        default: ;
      endcase
    end
  end

  // During DONE the fresh result is shown alongside the valid pulse; the
  // registered copy takes over from the following cycle.
  assign operand       = w_done ? w_result : r_operand;
  assign overflow      = w_done ? r_ovf    : r_overflow;
  assign operand_valid = w_done;
  assign digits        = r_digits;
  assign digit_count   = r_count;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_decimal_operand_entry.sv
// ---------------------------------------------------------------------------
// tb_decimal_operand_entry
//
// Directed stimulus with hand-computed results. Each commit pushes its
// expected operand, overflow flag and arrival cycle into a scoreboard queue;
// a monitor pops and compares whenever operand_valid is seen. Entry-register
// and control outputs are compared directly after each key sequence.
// Define DECIMAL_OPERAND_ENTRY_DEBOUNCE_EN to also exercise the debouncer.
// ---------------------------------------------------------------------------
module tb_decimal_operand_entry;

  localparam int WIDTH   = 7;
  localparam int NDIGITS = 4;
  localparam int DB      = 8;
`ifdef DECIMAL_OPERAND_ENTRY_DEBOUNCE_EN
  localparam int EV_OFF  = 2 + DB;   // sync + filter delay to the event cycle
  localparam int HOLD    = 20;
  localparam int GAP     = 20;
`else
  localparam int EV_OFF  = 2;        // two synchroniser flops
  localparam int HOLD    = 3;
  localparam int GAP     = 3;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [3:0]           key_code;
  logic                 key_strobe;
  logic                 key_enter;
  logic                 key_clear;
  logic [WIDTH-1:0]     operand;
  logic                 operand_valid;
  logic                 overflow;
  logic [4*NDIGITS-1:0] digits;
  logic [2:0]           digit_count;
  logic                 busy;

  decimal_operand_entry #(
    .WIDTH          (WIDTH),
    .NDIGITS        (NDIGITS),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_code     (key_code),
    .key_strobe   (key_strobe),
    .key_enter    (key_enter),
    .key_clear    (key_clear),
    .operand      (operand),
    .operand_valid(operand_valid),
    .overflow     (overflow),
    .digits       (digits),
    .digit_count  (digit_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] op;
    logic             ovf;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding commit.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && operand_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(operand_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("operand",       32'(operand),  32'(e.op));
        check("overflow",      32'(overflow), 32'(e.ovf));
        check("valid_latency", 32'(cyc),      32'(e.due));
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // One press of any button combination; optionally schedule a commit.
  task automatic press(input logic s, input logic e, input logic c,
                       input logic [3:0] code, input bit exp_v,
                       input logic [WIDTH-1:0] exp_op, input logic exp_ovf);
    int t0;
    exp_t x;
    @(negedge clk);
    t0 = cyc;
    if (exp_v) begin
      x.op  = exp_op;
      x.ovf = exp_ovf;
      x.due = t0 + EV_OFF + NDIGITS + 1;
      sb.push_back(x);
    end
    key_code   = code;
    key_strobe = s;
    key_enter  = e;
    key_clear  = c;
    repeat (HOLD) @(negedge clk);
    key_strobe = 1'b0;
    key_enter  = 1'b0;
    key_clear  = 1'b0;
    repeat (GAP) @(negedge clk);
    if (exp_v) wait_until(t0 + EV_OFF + NDIGITS + 3);
  endtask

  task automatic key(input logic [3:0] code);
    press(1'b1, 1'b0, 1'b0, code, 1'b0, '0, 1'b0);
  endtask

  task automatic enter(input logic [WIDTH-1:0] op, input logic ovf);
    press(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, op, ovf);
  endtask

  task automatic clear();
    press(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, '0, 1'b0);
  endtask

  task automatic check_entry(input string name, input logic [15:0] d, input logic [2:0] n);
    check({name, "_digits"}, 32'(digits), 32'(d));
    check({name, "_count"},  32'(digit_count), 32'(n));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int t0;
    reset      = 1'b1;
    key_code   = 4'd0;
    key_strobe = 1'b0;
    key_enter  = 1'b0;
    key_clear  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_operand",  32'(operand), 32'd0);
    check("rst_valid",    32'(operand_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check_entry("rst", 16'h0000, 3'd0);
    check("rst_busy",     32'(busy), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: plain in-range entry
    key(4'd1); key(4'd2); key(4'd7);
    check_entry("t1", 16'h0127, 3'd3);
    enter(7'd127, 1'b0);
    check_entry("t1_retained", 16'h0127, 3'd3);

    // 2: saturation, then clear and a zero commit
    clear();
    key(4'd1); key(4'd2); key(4'd8);
    enter(7'd127, 1'b1);
    check("t2_ovf_held", 32'(overflow), 32'd1);
    clear();
    check("t2_clear_ovf", 32'(overflow), 32'd0);
    key(4'd0); key(4'd0);
    enter(7'd0, 1'b0);

    // 3: full register, invalid code, clear beats strobe
    clear();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    check_entry("t3_full", 16'h1234, 3'd4);
    clear();
    check_entry("t3_clear", 16'h0000, 3'd0);
    key(4'hC);
    check_entry("t3_badcode", 16'h0000, 3'd0);
    key(4'd3);
    check_entry("t3_one", 16'h0003, 3'd1);
    press(1'b1, 1'b0, 1'b1, 4'd7, 1'b0, '0, 1'b0);
    check_entry("t3_clr_vs_strobe", 16'h0000, 3'd0);

    // Extra commits: empty entry, 4-digit overflow, strobe+enter together, 99
    enter(7'd0, 1'b0);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    enter(7'd127, 1'b1);
    clear();
    press(1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 7'd5, 1'b0);
    check_entry("strobe_enter", 16'h0005, 3'd1);
    clear();
    key(4'd9); key(4'd9);
    enter(7'd99, 1'b0);
    check("op_99_held", 32'(operand), 32'd99);

    // 4: clear during CONVERT aborts the commit
    clear();
    key(4'd4);
    @(negedge clk);
    t0 = cyc;
    key_enter = 1'b1;
    wait_until(t0 + 2);
    key_clear = 1'b1;
    wait_until(t0 + EV_OFF + 1);
    check("t4_busy_convert", 32'(busy), 32'd1);
    wait_until(t0 + EV_OFF + 3);
    check("t4_busy_after_clear", 32'(busy), 32'd0);
    check("t4_operand_kept", 32'(operand), 32'd99);
    check_entry("t4", 16'h0000, 3'd0);
    key_enter = 1'b0;
    key_clear = 1'b0;
    repeat (HOLD + GAP + 8) @(negedge clk);

    // 4b: reset mid-CONVERT
    key(4'd6);
    @(negedge clk);
    t0 = cyc;
    key_enter = 1'b1;
    wait_until(t0 + EV_OFF + 2);
    reset = 1'b1;
    @(negedge clk);
    check("rst2_operand",  32'(operand), 32'd0);
    check("rst2_valid",    32'(operand_valid), 32'd0);
    check("rst2_overflow", 32'(overflow), 32'd0);
    check_entry("rst2", 16'h0000, 3'd0);
    check("rst2_busy",     32'(busy), 32'd0);
    key_enter = 1'b0;
    reset     = 1'b0;
    repeat (HOLD + GAP + 8) @(negedge clk);

`ifdef DECIMAL_OPERAND_ENTRY_DEBOUNCE_EN
    // 5: a 5-cycle glitch is filtered; a 20-cycle press yields one digit
    key_code   = 4'd3;
    key_strobe = 1'b1;
    repeat (5) @(negedge clk);
    key_strobe = 1'b0;
    repeat (GAP) @(negedge clk);
    check_entry("t5_glitch", 16'h0000, 3'd0);
    key(4'd3);
    check_entry("t5_press", 16'h0003, 3'd1);
`endif

    // Drain: every scheduled commit must have arrived.
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("pending_commits", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
